// File: rtl/evrisim_birimi_p.sv
// evrisim_birimi_p : streaming 3x3 convolution with zero padding ("same" size).
//
// One raster-order pixel is accepted per cycle (veri_etkin_i && veri_hazir_o).
// Two line buffers and a 3x3 window form the neighbourhood. A three-stage
// pipeline then computes the result:
//   stage 1 : masked products
//   stage 2 : sum
//   stage 3 : arithmetic shift, optional abs, saturate
// After the last pixel of a frame, IMG_W+1 zero flush slots drain the window.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   filtre_etkin_i       loads filtre_i / kaydirma_i / mutlak_i while idle
//   filtre_i             k0..k8 signed coefficients, k0 (top-left) in MSBs
//   kaydirma_i           arithmetic right shift applied to the sum
//   mutlak_i             take |sum| before saturation
//   veri_etkin_i/veri_i  input pixel stream
//   veri_hazir_o         block accepts a pixel this cycle
//   veri_etkin_o/veri_o  output pixel stream
//   cerceve_son_o        marks the last output pixel of a frame
//   mesgul_o             frame in progress or pipeline not empty
module evrisim_birimi_p #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  filtre_etkin_i,
    input  logic [9*COEF_W-1:0]   filtre_i,
    input  logic [4:0]            kaydirma_i,
    input  logic                  mutlak_i,
    input  logic                  veri_etkin_i,
    input  logic [PIX_W-1:0]      veri_i,
    output logic                  veri_hazir_o,
    output logic                  veri_etkin_o,
    output logic [PIX_W-1:0]      veri_o,
    output logic                  cerceve_son_o,
    output logic                  mesgul_o
);
    localparam int N_PIX  = IMG_W * IMG_H;
    localparam int N_SLOT = N_PIX + IMG_W + 1;
    localparam int POS_W  = $clog2(N_SLOT + 1);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int PW     = PIX_W + 1 + COEF_W;
    localparam int SW     = PIX_W + COEF_W + 4;

    typedef enum logic [1:0] {BOSTA = 2'd0, AKIS = 2'd1, BOSALT = 2'd2} durum_t;

    // Zero-extended pixel times sign-extended coefficient.
    function automatic logic signed [PW-1:0] tap_mul(input logic [PIX_W-1:0] p,
                                                     input logic [COEF_W-1:0] k);
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        a = {{(PW-PIX_W){1'b0}}, p};
        b = {{(PW-COEF_W){k[COEF_W-1]}}, k};
        return a * b;
    endfunction

    // Shift, optional magnitude, then clamp to the unsigned pixel range.
    function automatic logic [PIX_W-1:0] sat_pix(input logic signed [SW-1:0] v,
                                                 input logic [4:0] sh,
                                                 input logic ab);
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] max_v;
        logic [PIX_W-1:0]     r;
        max_v = {{(SW-PIX_W){1'b0}}, {PIX_W{1'b1}}};
        s = v >>> sh;
        if (ab && (s < 0)) begin
            s = -s;
        end else begin
            s = s;
        end
        if (s < 0) begin
            r = '0;
        end else if (s > max_v) begin
            r = {PIX_W{1'b1}};
        end else begin
            r = s[PIX_W-1:0];
        end
        return r;
    endfunction

    durum_t                   state_r, state_s;
    logic [POS_W-1:0]         pos_r;
    logic [COL_W-1:0]         col_r;
    logic [COL_W-1:0]         cc_r;
    logic [ROW_W-1:0]         cr_r;
    logic                     hazir_r, mesgul_r;
    logic                     accept_s, slot_s, out_slot_s, last_s;
    logic [PIX_W-1:0]         x_s;
    logic [8:0]               mask_s, mask_r;
    logic [PIX_W-1:0]         lb0_r [IMG_W];
    logic [PIX_W-1:0]         lb1_r [IMG_W];
    logic [PIX_W-1:0]         win_r [9];
    logic [9*COEF_W-1:0]      coef_r;
    logic [4:0]               sh_r, sh_p1_r, sh_p2_r;
    logic                     abs_r, abs_p1_r, abs_p2_r;
    logic                     vw_r, vp1_r, vp2_r, lw_r, lp1_r, lp2_r;
    logic signed [PW-1:0]     prod_s [9];
    logic signed [PW-1:0]     prod_r [9];
    logic signed [SW-1:0]     sum_s, sum_r;
    logic                     vo_r, son_r;
    logic [PIX_W-1:0]         veri_r;

    assign veri_hazir_o  = hazir_r;
    assign mesgul_o      = mesgul_r;
    assign veri_etkin_o  = vo_r;
    assign veri_o        = veri_r;
    assign cerceve_son_o = son_r;

    // Slot decode: accepted pixels, or zero-filled flush slots while draining.
    always_comb begin
        accept_s = veri_etkin_i && hazir_r;
        slot_s   = accept_s || (state_r == BOSALT);
        if (state_r == BOSALT) begin
            x_s = '0;
        end else begin
            x_s = veri_i;
        end
        out_slot_s = slot_s && (pos_r >= POS_W'(IMG_W + 1));
        last_s     = (cc_r == COL_W'(IMG_W - 1)) && (cr_r == ROW_W'(IMG_H - 1));
    end

    // Padding mask from the centre row/column; buffer contents are never trusted at borders.
    always_comb begin
        logic [2:0] row_ok;
        logic [2:0] col_ok;
        row_ok = {cr_r != ROW_W'(IMG_H - 1), 1'b1, cr_r != ROW_W'(0)};
        col_ok = {cc_r != COL_W'(IMG_W - 1), 1'b1, cc_r != COL_W'(0)};
        mask_s = '0;
        for (int i = 0; i < 9; i++) begin
            mask_s[i] = row_ok[i/3] && col_ok[i%3];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            BOSTA: begin
                if (accept_s) state_s = AKIS;
                else          state_s = BOSTA;
            end
            AKIS: begin
                if (accept_s && (pos_r == POS_W'(N_PIX - 1))) state_s = BOSALT;
                else                                          state_s = AKIS;
            end
            BOSALT: begin
                if (pos_r == POS_W'(N_SLOT - 1)) state_s = BOSTA;
                else                             state_s = BOSALT;
            end
            default: state_s = BOSTA;
        endcase
    end

    // State, position counters, configuration and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= BOSTA;
            pos_r    <= '0;
            col_r    <= '0;
            cc_r     <= '0;
            cr_r     <= '0;
            hazir_r  <= 1'b1;
            mesgul_r <= 1'b0;
            coef_r   <= '0;
            coef_r[4*COEF_W +: COEF_W] <= COEF_W'(1);
            sh_r     <= 5'd0;
            abs_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            hazir_r  <= (state_s != BOSALT);
            mesgul_r <= (state_s != BOSTA) || out_slot_s || vw_r || vp1_r;
            if (filtre_etkin_i && (state_r == BOSTA)) begin
                coef_r <= filtre_i;
                sh_r   <= kaydirma_i;
                abs_r  <= mutlak_i;
            end
            if (slot_s) begin
                if (pos_r == POS_W'(N_SLOT - 1)) begin
                    pos_r <= '0;
                    col_r <= '0;
                end else begin
                    pos_r <= pos_r + POS_W'(1);
                    col_r <= (col_r == COL_W'(IMG_W - 1)) ? '0 : col_r + COL_W'(1);
                end
            end
            if (out_slot_s) begin
                if (cc_r == COL_W'(IMG_W - 1)) begin
                    cc_r <= '0;
                    cr_r <= (cr_r == ROW_W'(IMG_H - 1)) ? '0 : cr_r + ROW_W'(1);
                end else begin
                    cc_r <= cc_r + COL_W'(1);
                end
            end
        end
    end

    // Line buffers: lb0 holds the previous row, lb1 the one before.
    always_ff @(posedge clk_i) begin
        if (slot_s) begin
            lb0_r[col_r] <= x_s;
            lb1_r[col_r] <= lb0_r[col_r];
        end
    end

    // 3x3 window shift; the newest pixel enters at bottom-right (tap 8).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 9; i++) win_r[i] <= '0;
            mask_r <= '0;
            vw_r   <= 1'b0;
            lw_r   <= 1'b0;
        end else begin
            vw_r <= out_slot_s;
            if (slot_s) begin
                win_r[0] <= win_r[1];
                win_r[1] <= win_r[2];
                win_r[2] <= lb1_r[col_r];
                win_r[3] <= win_r[4];
                win_r[4] <= win_r[5];
                win_r[5] <= lb0_r[col_r];
                win_r[6] <= win_r[7];
                win_r[7] <= win_r[8];
                win_r[8] <= x_s;
                mask_r   <= mask_s;
                lw_r     <= out_slot_s && last_s;
            end
        end
    end

    // Stage 1 operands: masked taps give zero products.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            if (mask_r[i]) prod_s[i] = tap_mul(win_r[i], coef_r[(8-i)*COEF_W +: COEF_W]);
            else           prod_s[i] = '0;
        end
    end

    // Stage 2 operand: wide sum, cannot overflow.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < 9; i++) begin
            sum_s = sum_s + {{(SW-PW){prod_r[i][PW-1]}}, prod_r[i]};
        end
    end

    // Pipeline stages 1..3; shift/abs travel with the data so idle reloads cannot touch draining results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 9; i++) prod_r[i] <= '0;
            vp1_r <= 1'b0; lp1_r <= 1'b0; sh_p1_r <= 5'd0; abs_p1_r <= 1'b0;
            sum_r <= '0;
            vp2_r <= 1'b0; lp2_r <= 1'b0; sh_p2_r <= 5'd0; abs_p2_r <= 1'b0;
            vo_r  <= 1'b0; son_r <= 1'b0; veri_r <= '0;
        end else begin
            vp1_r <= vw_r;
            vp2_r <= vp1_r;
            vo_r  <= vp2_r;
            son_r <= vp2_r && lp2_r;
            if (vw_r) begin
                for (int i = 0; i < 9; i++) prod_r[i] <= prod_s[i];
                lp1_r <= lw_r; sh_p1_r <= sh_r; abs_p1_r <= abs_r;
            end
            if (vp1_r) begin
                sum_r <= sum_s;
                lp2_r <= lp1_r; sh_p2_r <= sh_p1_r; abs_p2_r <= abs_p1_r;
            end
            if (vp2_r) begin
                veri_r <= sat_pix(sum_r, sh_p2_r, abs_p2_r);
            end
        end
    end
endmodule

// File: tb/tb_evrisim_birimi_p.sv
// Self-checking bench for evrisim_birimi_p on a 4x3 image. A reference
// convolution pushes expected results to a queue when each frame is driven;
// a negedge monitor pops and compares them as outputs appear.
module tb_evrisim_birimi_p;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rst;
    logic         filtre_etkin_i;
    logic [71:0]  filtre_i;
    logic [4:0]   kaydirma_i;
    logic         mutlak_i;
    logic         veri_etkin_i;
    logic [7:0]   veri_i;
    logic         veri_hazir_o, veri_etkin_o, cerceve_son_o, mesgul_o;
    logic [7:0]   veri_o;

    typedef struct packed {
        logic       son;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   img [N];
    int   cfg_k [9];
    int   cfg_sh;
    bit   cfg_abs;

    always #5 clk = ~clk;

    evrisim_birimi_p #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .COEF_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .filtre_etkin_i(filtre_etkin_i), .filtre_i(filtre_i),
        .kaydirma_i(kaydirma_i), .mutlak_i(mutlak_i),
        .veri_etkin_i(veri_etkin_i), .veri_i(veri_i),
        .veri_hazir_o(veri_hazir_o), .veri_etkin_o(veri_etkin_o),
        .veri_o(veri_o), .cerceve_son_o(cerceve_son_o), .mesgul_o(mesgul_o)
    );

    // Output monitor: every valid output must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && veri_etkin_o) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed=%0d expected=none", veri_o);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks += 2;
                assert (veri_o === mon_e.val) else begin
                    errors++;
                    $error("FAIL pixel observed=%0d expected=%0d", veri_o, mon_e.val);
                end
                assert (cerceve_son_o === mon_e.son) else begin
                    errors++;
                    $error("FAIL frame_last observed=%0b expected=%0b", cerceve_son_o, mon_e.son);
                end
            end
        end else if (!rst) begin
            checks++;
            assert (cerceve_son_o === 1'b0) else begin
                errors++;
                $error("FAIL last_without_valid observed=%0b expected=0", cerceve_son_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_cfg(input int k0, input int k1, input int k2, input int k3, input int k4,
                           input int k5, input int k6, input int k7, input int k8,
                           input int sh, input bit ab);
        cfg_k[0] = k0; cfg_k[1] = k1; cfg_k[2] = k2;
        cfg_k[3] = k3; cfg_k[4] = k4; cfg_k[5] = k5;
        cfg_k[6] = k6; cfg_k[7] = k7; cfg_k[8] = k8;
        cfg_sh = sh; cfg_abs = ab;
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < 9; i++) filtre_i[(8-i)*8 +: 8] = 8'(cfg_k[i]);
        kaydirma_i = 5'(cfg_sh);
        mutlak_i   = cfg_abs;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    // Reference zero-padded convolution of img with the modelled configuration.
    task automatic push_expected();
        exp_t e;
        int   s, rr, cc;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                s = 0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        rr = r + dr - 1;
                        cc = c + dc - 1;
                        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                            s += cfg_k[dr*3+dc] * img[rr*W+cc];
                    end
                end
                s = s >>> cfg_sh;
                if (cfg_abs && s < 0) s = -s;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                e.son = (r == H-1) && (c == W-1);
                e.val = 8'(s);
                exp_q.push_back(e);
            end
        end
    endtask

    // Offer one pixel from a negedge until it is accepted; returns on the following negedge.
    task automatic send_pixel(input logic [7:0] v);
        int n;
        n = 0;
        veri_etkin_i = 1'b1;
        veri_i = v;
        while (!veri_hazir_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        veri_etkin_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("idle_busy", mesgul_o, 0);
        chk("idle_ready", veri_hazir_o, 1);
    endtask

    task automatic run_frame(input bit load, input bit gaps, input bit pulse, input bit probe);
        push_expected();
        for (int i = 0; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (load && i == 0) begin
                drive_cfg();
                filtre_etkin_i = 1'b1;
            end
            if (pulse && i == 6) begin
                filtre_i = {9{8'hFF}};
                kaydirma_i = 5'd7;
                mutlak_i = 1'b1;
                filtre_etkin_i = 1'b1;
            end
            send_pixel(8'(img[i]));
            filtre_etkin_i = 1'b0;
            if (i == 3) chk("busy_mid", mesgul_o, 1);
        end
        if (probe) begin
            veri_etkin_i = 1'b1;
            veri_i = 8'd77;
            for (int k = 0; k < W + 1; k++) begin
                chk("flush_stall", veri_hazir_o, 0);
                @(negedge clk);
            end
            veri_etkin_i = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        rst = 1'b1;
        filtre_etkin_i = 1'b0; filtre_i = '0; kaydirma_i = 5'd0; mutlak_i = 1'b0;
        veri_etkin_i = 1'b0; veri_i = 8'd0;
        set_cfg(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", veri_hazir_o, 1);
        chk("rst_valid", veri_etkin_o, 0);
        chk("rst_data", veri_o, 0);
        chk("rst_last", cerceve_son_o, 0);
        chk("rst_busy", mesgul_o, 0);

        // Identity default: ramp passes through unchanged.
        for (int i = 0; i < N; i++) img[i] = i * 20 + 3;
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        // Box kernel on flat 10: corners 40, edges 60, interior 90.
        set_cfg(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1'b0);
        fill(10);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        // Laplacian on flat 10: corners 20, edges 10, interior 0.
        set_cfg(0, -1, 0, -1, 4, -1, 0, -1, 0, 0, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        // Spike of 100 with and without magnitude mode.
        fill(0);
        img[5] = 100;
        set_cfg(0, -1, 0, -1, 4, -1, 0, -1, 0, 0, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        cfg_abs = 1'b0;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation and shift.
        set_cfg(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1'b0);
        fill(255);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        cfg_sh = 3;
        fill(8);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        // Random image with gaps, ignored mid-frame load, stalled flush; then gapless repeat.
        set_cfg(1, 2, 1, 0, 0, 0, -1, -2, -1, 1, 1'b1);
        for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
        run_frame(1'b1, 1'b1, 1'b1, 1'b1);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset after pixel 5 with a result in flight; configuration returns to identity.
        for (int i = 0; i < 6; i++) send_pixel(8'(i + 50));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", veri_etkin_o, 0);
        chk("midrst_busy", mesgul_o, 0);
        exp_q.delete();
        set_cfg(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < N; i++) img[i] = 200 - i * 7;
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/evrisim_birimi_p.md
# evrisim_birimi_p

Parametrised streaming 3x3 convolution unit; successor to the fixed 320x240 convolution block, generalised in image size, pixel/coefficient width and normalisation. It sits between the pixel source and the edge/blur post-processing stages. It accepts one raster-order pixel per cycle with backpressure and emits exactly IMG_W*IMG_H zero-padded ("same"-size) results per frame. Signed coefficients, runtime shift, saturation and an absolute-value mode replace the old fixed gaussian/laplacian paths.

## Interface
- IMG_W, 320, pixels per row (>=3)
- IMG_H, 240, rows per frame (>=2)
- PIX_W, 8, unsigned pixel width
- COEF_W, 8, signed two's-complement coefficient width
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- filtre_etkin_i  input  1  load strobe for filtre_i/kaydirma_i/mutlak_i
- filtre_i  input  9*COEF_W  coefficients k0..k8, k0 (top-left) in MSBs, raster order, k4 = centre
- kaydirma_i  input  5  arithmetic right shift applied to the sum
- mutlak_i  input  1  1: take |sum| before saturation
- veri_etkin_i  input  1  input pixel valid
- veri_i  input  PIX_W  input pixel
- veri_hazir_o  output  1  block accepts a pixel this cycle
- veri_etkin_o  output  1  output pixel valid
- veri_o  output  PIX_W  output pixel
- cerceve_son_o  output  1  with veri_etkin_o, marks pixel IMG_W*IMG_H-1
- mesgul_o  output  1  frame in progress (state != BOSTA or pipeline non-empty)

## Operation
- Two line buffers of IMG_W x PIX_W plus a 3x3 window register; a pixel is accepted when veri_etkin_i && veri_hazir_o.
- States: BOSTA (idle) -> AKIS on first accepted pixel; AKIS -> BOSALT after accepting pixel IMG_W*IMG_H-1; BOSALT -> BOSTA after IMG_W+1 flush slots issued. veri_hazir_o = 1 in BOSTA and AKIS, 0 in BOSALT.
- Each accepted pixel or flush slot advances the window by one linear position; flush slots inject zeros. Output for linear index n is produced by the slot at linear position n+IMG_W+1; first IMG_W+1 slots of a frame produce no output.
- Padding: window taps outside the image (row -1, row IMG_H, column -1, column IMG_W) read as 0, using row/column counters, not buffer contents; no data from a previous row's end or previous frame leaks in.
- Arithmetic: each tap zero-extended to PIX_W+1 signed, multiplied by its coefficient; 9 products summed at PIX_W+COEF_W+4 bits, no overflow. Then arithmetic shift right by kaydirma_i, then |.| if mutlak_i, then saturate to [0, 2^PIX_W-1].
- Coefficients, shift and mode load only when filtre_etkin_i=1 in BOSTA (including the cycle that accepts the first pixel); ignored mid-frame. The configuration persists across frames.
- Back-to-back frames: a new frame starts only once BOSTA is re-entered; pixels offered during BOSALT are stalled.

## Timing
- Pipeline after the window: stage 1 products, stage 2 sum, stage 3 shift/abs/saturate register. veri_etkin_o asserts exactly 3 cycles after the slot that completes the window; input bubbles propagate as veri_etkin_o=0 gaps.
- With continuous input, the first output follows 3 cycles after accepting pixel IMG_W+1. The last output follows 3 cycles after the final flush slot. A frame takes IMG_W*IMG_H+IMG_W+1+3 cycles.
- Reset values: veri_hazir_o=1 (after rst_i falls), veri_etkin_o=0, veri_o=0, cerceve_son_o=0, mesgul_o=0. Coefficients reset to identity (k4=1, others 0), kaydirma=0, mutlak=0. State is BOSTA, counters are 0.
- rst_i mid-frame: all state, counters and pipeline valids clear immediately. The partial frame is discarded and no further outputs appear. The next frame starts cleanly from pixel 0.

## Test plan
- Defaults after reset, 320x240 ramp image, no filter load -> 76800 outputs, each equal to its input, cerceve_son_o only on the last output.
- IMG_W=4, IMG_H=3, all pixels 10, box kernel (all 1), shift 0 -> corners 40, edges 60, interior 90; exactly 12 outputs.
- Same frame, kernel {0,-1,0,-1,4,-1,0,-1,0} -> corners 20, edge 10, interior 0. Single 100 spike on zeros with mutlak_i=1 -> centre 255 (saturated), 4-neighbours 100; with mutlak_i=0 -> neighbours 0.
- All pixels 255, box kernel -> all 255 (saturate). All pixels 8, box, shift 3 -> interior 9, corners 4.
- Random veri_etkin_i gaps plus filtre_etkin_i pulsed mid-frame -> outputs identical to the gapless run, and the mid-frame config is ignored. Pixels offered during BOSALT -> veri_hazir_o=0 and none are consumed.
- rst_i asserted at pixel 5 of a 4x3 frame, then a full new frame -> no stale outputs; the new frame's 12 results are correct.
